// File: rtl/amc7823_pkg.sv
// Shared constants, command-word field map and FSM state encoding for the AMC7823 SPI master.
package amc7823_pkg;

  localparam int FRAME_BITS = 32;
  localparam int CMD_BITS   = 16;
  localparam int DATA_BITS  = FRAME_BITS - CMD_BITS;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  // Command-word field positions
  localparam int RW_BIT   = 15;
  localparam int PAGE_MSB = 13;
  localparam int PAGE_LSB = 12;
  localparam int ADDR_MSB = 5;
  localparam int ADDR_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_GAP
  } state_e;

  function automatic logic cmd_is_read(input logic [CMD_BITS-1:0] cmd);
    return cmd[RW_BIT];
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter: ticks on the last cycle of every DIV-cycle phase while enabled.
module spi_clk_div #(
  parameter int unsigned DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] r_cnt;
  logic       w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  // Held at zero while disabled so every frame starts phase-aligned to its first cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt <= 8'd0;
    end else if (w_last) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/amc7823_spi_master.sv
// 32-bit framed SPI master (16-bit command + 16-bit data) for the AMC7823; all pins registered.
module amc7823_spi_master
  import amc7823_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [CMD_BITS-1:0]  i_cmd,
  input  logic [DATA_BITS-1:0] i_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DATA_BITS-1:0] o_rdata,
  output logic                 o_ss,
  output logic                 o_sclk,
  output logic                 o_mosi,
  input  logic                 i_miso
);

  state_e                r_state, w_state_nxt;
  logic                  r_phase, w_phase_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [FRAME_BITS-1:0] r_tx, w_tx_nxt;
  logic [FRAME_BITS-1:0] r_rx, w_rx_nxt;

  logic                  w_tick;
  logic                  w_ss_nxt, w_sclk_nxt, w_mosi_nxt, w_busy_nxt, w_done_nxt;

  spi_clk_div #(.DIV(DIV)) u_clk_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (r_state != ST_IDLE),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_phase   <= 1'b0;
      r_bit_cnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      o_ss      <= 1'b1;
      o_sclk    <= 1'b0;
      o_mosi    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      o_ss      <= w_ss_nxt;
      o_sclk    <= w_sclk_nxt;
      o_mosi    <= w_mosi_nxt;
      o_busy    <= w_busy_nxt;
      o_done    <= w_done_nxt;
      if (w_done_nxt) begin
        o_rdata <= r_rx[DATA_BITS-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_LEAD;
          w_tx_nxt    = {i_cmd, i_wdata};
        end
      end
      ST_LEAD: begin
        if (w_tick) begin
          w_state_nxt   = ST_SHIFT;
          w_phase_nxt   = 1'b0;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
          end else begin
            // End of high phase: sample miso just before the falling edge
            w_phase_nxt = 1'b0;
            w_tx_nxt    = {r_tx[FRAME_BITS-2:0], 1'b0};
            w_rx_nxt    = {r_rx[FRAME_BITS-2:0], i_miso};
            if (r_bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
              w_state_nxt = ST_TRAIL;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
          end
        end
      end
      ST_TRAIL: begin
        if (w_tick) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (w_tick) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so the registered pins line up with it.
  always_comb begin
    w_ss_nxt   = !((w_state_nxt == ST_LEAD) || (w_state_nxt == ST_SHIFT) ||
                   (w_state_nxt == ST_TRAIL));
    w_sclk_nxt = (w_state_nxt == ST_SHIFT) && w_phase_nxt;
    w_mosi_nxt = (w_state_nxt == ST_SHIFT) ? w_tx_nxt[FRAME_BITS-1] : 1'b0;
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (r_state == ST_TRAIL) && w_tick;
  end

endmodule

// File: tb/tb_amc7823_spi_master.sv
// Bench for amc7823_spi_master: three instances (DIV=4, 2, 255) driven by a table, random frames and corner sequences.
module tb_amc7823_spi_master;

  logic            clk = 1'b0;
  logic [2:0]      rst = 3'b111;
  logic [2:0]      start = 3'b000;
  logic [2:0][15:0] cmd = '0;
  logic [2:0][15:0] wdata = '0;
  logic [2:0]      miso = 3'b000;
  logic [2:0]      busy, done, ss, sclk, mosi;
  logic [2:0][15:0] rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    amc7823_spi_master #(.DIV(g == 0 ? 4 : (g == 1 ? 2 : 255))) u_dut (
      .i_clk   (clk),
      .i_rst   (rst[g]),
      .i_start (start[g]),
      .i_cmd   (cmd[g]),
      .i_wdata (wdata[g]),
      .o_busy  (busy[g]),
      .o_done  (done[g]),
      .o_rdata (rdata[g]),
      .o_ss    (ss[g]),
      .o_sclk  (sclk[g]),
      .o_mosi  (mosi[g]),
      .i_miso  (miso[g])
    );
  end

  function automatic int div_of(input int idx);
    return (idx == 0) ? 4 : ((idx == 1) ? 2 : 255);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One frame on instance idx. The slave model presents pat MSB first, changing miso after
  // each sclk rise. Expected timing comes straight from the frame arithmetic in DIV units.
  task automatic run_frame(input int idx, input logic [15:0] c, input logic [15:0] w,
                           input logic [31:0] pat, input logic [15:0] exp_rd,
                           input int rst_cyc, input bit extra);
    int div = div_of(idx);
    int t = 0, ss_fall = -1, first_rise = -1, n_rise = 0, k = 0;
    int done_cyc = -1, n_done = 0, busy_fall = -1, hi_len = 0, idle_bad = 0;
    logic prev_sclk = 1'b0;
    logic [31:0] mo = '0;
    logic [15:0] rd = '0;
    @(negedge clk);
    cmd[idx] = c; wdata[idx] = w; miso[idx] = 1'b0; start[idx] = 1'b1;
    while (busy_fall < 0 && t < 67 * div + 20) begin
      @(negedge clk);
      t++;
      start[idx] = extra && (t == 10 || t == 265);
      if (t == 1) chk("busy_rise", busy[idx], 1);
      if (rst_cyc > 0 && t == rst_cyc) begin
        chk("pre_rst_ss", ss[idx], 0);
        rst[idx] = 1'b1;
      end
      if (rst_cyc > 0 && t == rst_cyc + 1) begin
        chk("rst_ss", ss[idx], 1);
        chk("rst_sclk", sclk[idx], 0);
        chk("rst_busy", busy[idx], 0);
        chk("rst_rdata", rdata[idx], 0);
        rst[idx] = 1'b0;
      end
      if (ss_fall < 0 && !ss[idx]) ss_fall = t;
      if (sclk[idx] && !prev_sclk) begin
        if (first_rise < 0) first_rise = t;
        if (!ss[idx]) n_rise++;
        mo = {mo[30:0], mosi[idx]};
        if (k < 32) miso[idx] = pat[31 - k];
        k++;
      end
      if (sclk[idx] && ss[idx]) idle_bad++;
      if (n_rise == 1 && sclk[idx]) hi_len++;
      if (done[idx]) begin
        n_done++;
        done_cyc = t;
        rd = rdata[idx];
        chk("ss_at_done", ss[idx], 1);
      end
      if (!busy[idx]) busy_fall = t;
      prev_sclk = sclk[idx];
    end
    chk("sclk_idle_low", idle_bad, 0);
    if (rst_cyc > 0) begin
      chk("rst_no_done", n_done, 0);
      chk("rst_busy_fall", busy_fall, rst_cyc + 1);
    end else begin
      chk("ss_fall_cyc", ss_fall, 1);
      chk("first_rise_cyc", first_rise, 2 * div + 1);
      chk("n_rises", n_rise, 32);
      chk("sclk_high_len", hi_len, div);
      chk("mosi_word", mo, {c, w});
      chk("n_done", n_done, 1);
      chk("done_cyc", done_cyc, 66 * div + 1);
      chk("rdata_at_done", rd, exp_rd);
      chk("rdata_held", rdata[idx], exp_rd);
      chk("busy_fall_cyc", busy_fall, 67 * div + 1);
    end
  endtask

  typedef struct {
    int          idx;
    logic [15:0] c;
    logic [15:0] w;
    logic [31:0] pat;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Toggling loopback (0 then flip on every rise) is the pattern 0xAAAAAAAA.
    tbl[0] = '{0, 16'h8000, 16'h0000, 32'hAAAA_AAAA, 16'hAAAA};
    tbl[1] = '{1, 16'h1234, 16'hABCD, 32'hAAAA_AAAA, 16'hAAAA};
    tbl[2] = '{1, 16'hFFFF, 16'h0000, 32'h0000_FFFF, 16'hFFFF};
    tbl[3] = '{0, 16'h0000, 16'hFFFF, 32'h1234_5678, 16'h5678};

    repeat (3) @(negedge clk);
    rst = 3'b000;
    @(negedge clk);
    chk("reset_ss", ss, 3'b111);
    chk("reset_sclk", sclk, 3'b000);
    chk("reset_mosi", mosi, 3'b000);
    chk("reset_busy", busy, 3'b000);
    chk("reset_done", done, 3'b000);
    for (int i = 0; i < 3; i++) chk("reset_rdata", rdata[i], 0);

    for (int i = 0; i < 4; i++)
      run_frame(tbl[i].idx, tbl[i].c, tbl[i].w, tbl[i].pat, tbl[i].exp_rd, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] p;
      logic [15:0] rc, rw;
      p = $urandom; rc = 16'($urandom); rw = 16'($urandom);
      run_frame(i % 2, rc, rw, p, p[15:0], 0, 1'b0);
    end

    // Starts in cycles 10 and 265 are ignored; one in cycle 269 is accepted.
    run_frame(0, 16'h8000, 16'h0000, 32'hAAAA_AAAA, 16'hAAAA, 0, 1'b1);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("restart_ss", ss[0], 0);
    chk("restart_busy", busy[0], 1);
    begin
      int n = 0;
      while (busy[0] && n < 400) begin @(negedge clk); n++; end
      chk("restart_completes", busy[0], 0);
    end

    run_frame(0, 16'h8123, 16'h5555, 32'hFFFF_FFFF, 16'hFFFF, 100, 1'b0);

    @(negedge clk);
    rst[1] = 1'b1; start[1] = 1'b1; cmd[1] = 16'h8000;
    @(negedge clk);
    rst[1] = 1'b0; start[1] = 1'b0;
    begin
      int ss_bad = 0, busy_bad = 0;
      for (int i = 0; i < 10; i++) begin
        if (!ss[1]) ss_bad++;
        if (busy[1]) busy_bad++;
        @(negedge clk);
      end
      chk("rst_start_ss", ss_bad, 0);
      chk("rst_start_busy", busy_bad, 0);
    end

    begin
      logic [31:0] p;
      p = $urandom;
      run_frame(2, 16'hC00A, 16'h0F0F, p, p[15:0], 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/amc7823_spi_master.md
# amc7823_spi_master

SPI master that runs 32-bit transactions (16-bit command, 16-bit data) against the AMC7823 housekeeping ADC/DAC on the digitizer board. It sits directly upstream of the chip pins (ss, sclk, mosi, miso) and is driven by a local-bus register bank. Each request produces one framed transaction. Read data returns with a one-cycle done strobe.

## Interface
- DIV, 4: sclk half-period in clk cycles; legal range 2..255.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; honoured only when busy=0.
- cmd  input  16  command word (R/W bit, page, address); captured on accepted start.
- wdata  input  16  data word sent after cmd; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start until the inter-frame gap ends.
- done  output  1  one-cycle pulse when the frame completes.
- rdata  output  16  last 16 bits shifted in from miso; updated with done, held until the next done.
- ss  output  1  chip select, active low.
- sclk  output  1  serial clock, idle low.
- mosi  output  1  serial data out, MSB first.
- miso  input  1  serial data in, MSB first.

## Operation
- States: IDLE, LEAD, SHIFT, TRAIL, GAP.
- IDLE: ss=1, sclk=0, busy=0. On start=1, latch {cmd,wdata} into a 32-bit tx shift register, then go to LEAD.
- LEAD: ss=0, sclk=0 for DIV cycles, then go to SHIFT with bit counter 0.
- SHIFT, per bit (32 bits):
  - Low phase (DIV cycles): mosi = tx[31] from the first cycle of the phase; sclk=0.
  - High phase (DIV cycles): sclk=1.
  - On the last cycle of the high phase, shift miso into a 32-bit rx register and shift tx left.
  - After bit 31, go to TRAIL.
- TRAIL: ss=0, sclk=0 for DIV cycles. On exit, set ss=1, pulse done, load rdata = rx[15:0], and go to GAP.
- GAP: ss=1 for DIV cycles, busy=1, then go to IDLE.
- start while busy=1 is ignored; no queueing.
- mosi is driven 0 outside SHIFT.
- Reset values: ss=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, state IDLE.
- Reset mid-frame: on the next edge, ss=1 and sclk=0; no done; rdata goes to 0.
- rst and start in the same cycle: reset wins, start is dropped.
- Half-period counter width is 8 bits.
- Bit counter counts 0..31 and does not wrap within a frame.

## Timing
- All outputs are registered; there are no combinational paths from inputs to pins.
- Start accepted in cycle 0. Then:
  - ss falls in cycle 1.
  - First sclk rise in cycle 2·DIV+1.
  - done and ss rise in cycle 66·DIV+1.
  - busy falls in cycle 67·DIV+1.
- The next start is accepted in cycle 67·DIV+1 or later.
- sclk frequency is f_clk/(2·DIV). The duty cycle is exactly 50%.
- Each mosi bit is stable for DIV cycles before and DIV cycles after its sclk rising edge.
- miso is sampled DIV−1 cycles after the rising edge, i.e. just before the falling edge.

## Structure
- Shared package amc7823_pkg holds:
  - FRAME_BITS=32 and CMD_BITS=16.
  - The state enum.
  - Command-word field positions: R/W bit 15, page bits 13:12, address bits 5:0.
- One natural sub-module: spi_clk_div, the half-period counter. It takes DIV and emits phase-end ticks.
- Everything else lives in a single FSM module.

## Test plan
- Loopback via amc7823_sim (miso toggles on every sclk rise, starting at 0), DIV=4, start with cmd=0x8000, wdata=0x0000 -> done in cycle 265, rdata=0xAAAA, busy low in cycle 269.
- cmd=0x1234, wdata=0xABCD, DIV=2 -> mosi captured at sclk rises yields 0x1234ABCD; exactly 32 sclk rising edges while ss=0; sclk low whenever ss=1.
- start pulsed in cycles 0, 10 and 265 (DIV=4) -> only one frame, one done; the cycle-269 start is accepted.
- rst asserted in cycle 100 of a frame -> in cycle 101: ss=1, sclk=0, busy=0, rdata=0; no done pulse.
- rst=1 and start=1 in the same cycle -> ss stays 1; no frame.
- DIV=255 -> sclk half-period measured as 255 clk cycles; done in cycle 16831.
